// File: rtl/merak_channel_grant_decoder.sv
// merak_channel_grant_decoder
//
// Registered 4-to-16 grant decoder for the Merak channel arbiter.
// It takes an encoded channel request and drives a one-hot grant to that
// channel. The grant is held until one of these happens:
//   - the channel signals done
//   - abort is raised
//   - the grant has lasted TIMEOUT cycles
// Every grant is followed by one RELEASE cycle with no grant, so two
// grants are never asserted together.
//
// Ports:
//   clk          clock; all state changes on its rising edge
//   rst_n        synchronous active-low reset
//   req_valid    an encoded channel request is present
//   req_id       encoded channel index (valid with req_valid)
//   req_ready    block is idle and will accept a request this cycle
//   grant        registered one-hot grant, bit i -> channel i
//   grant_id     registered index of the current / last granted channel
//   busy         registered, high while granting or releasing
//   done         per-channel completion; only done[grant_id] matters
//   abort        forces release of the active grant, no error reported
//   timeout_err  registered one-cycle pulse when a grant expires
module merak_channel_grant_decoder #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [3:0]  req_id,
  output logic        req_ready,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        busy,
  input  logic [15:0] done,
  input  logic        abort,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Last value of the grant counter before the grant expires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [15:0]        grant_q, grant_d;
  logic [3:0]         grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [15:0]        req_onehot;
  logic               done_hit;

  // One comparator per channel turns the encoded index into a one-hot grant.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign req_onehot[gi] = (req_id == 4'(gi));
    end
  endgenerate

  // Only the currently granted channel may end its own grant.
  assign done_hit = done[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_GRANT;
          grant_d    = req_onehot;
          grant_id_d = req_id;
          cnt_d      = '0;
        end
      end
      S_GRANT: begin
        // done has priority over abort, and abort over timeout. As a
        // result, a grant that completes on its final cycle never
        // reports an error.
        if (done_hit || abort) begin
          state_d = S_RELEASE;
          grant_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_RELEASE;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d == S_GRANT) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_merak_channel_grant_decoder.sv
// Testbench for merak_channel_grant_decoder (TIMEOUT=4).
//
// A transaction-level model tracks which channel holds the grant, how
// many cycles it has held it, and whether a release gap is in progress.
// It is compared against the DUT on every falling edge. Directed steps
// also check hand-computed literal values.
module tb_merak_channel_grant_decoder;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_id = 4'd0;
  logic        req_ready;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic [15:0] done = 16'h0000;
  logic        abort = 1'b0;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  merak_channel_grant_decoder #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id),
    .req_ready(req_ready), .grant(grant), .grant_id(grant_id), .busy(busy),
    .done(done), .abort(abort), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  int  m_ch    = -1;   // granted channel, -1 when no grant
  int  m_age   = 0;    // grant cycles completed so far
  bit  m_gap   = 0;    // one-cycle release gap in progress
  int  m_last  = 0;    // last granted channel
  bit  m_terr  = 0;
  bit  m_valid = 0;    // model is meaningful once a reset edge was seen

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ch = -1; m_age = 0; m_gap = 0; m_last = 0; m_terr = 0; m_valid = 1;
    end else begin
      m_terr = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_ch >= 0) begin
        m_age = m_age + 1;
        if (done[m_ch] || abort) begin
          m_ch = -1; m_gap = 1;
        end else if (m_age == TMO) begin
          m_ch = -1; m_gap = 1; m_terr = 1;
        end
      end else if (req_valid) begin
        m_ch = int'(req_id); m_last = int'(req_id); m_age = 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp("m_grant", grant, (m_ch >= 0) ? (16'h1 << m_ch) : 16'h0);
      cmp("m_grant_id", {12'h0, grant_id}, 16'(m_last));
      cmp("m_busy", {15'h0, busy}, {15'h0, (m_ch >= 0) || m_gap});
      cmp("m_ready", {15'h0, req_ready}, {15'h0, !((m_ch >= 0) || m_gap)});
      cmp("m_terr", {15'h0, timeout_err}, {15'h0, m_terr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick(); tick();
    cmp("rst_grant", grant, 16'h0000);
    cmp("rst_id", {12'h0, grant_id}, 16'h0);
    cmp("rst_busy", {15'h0, busy}, 16'h0);
    cmp("rst_ready", {15'h0, req_ready}, 16'h1);
    $display("txn reset: grant=%h ready=%b", grant, req_ready);

    // Accept channel 5, release via done[5].
    rst_n = 1'b1; req_valid = 1'b1; req_id = 4'd5;
    tick(); req_valid = 1'b0;
    cmp("ch5_grant", grant, 16'h0020);
    cmp("ch5_id", {12'h0, grant_id}, 16'h5);
    cmp("ch5_busy", {15'h0, busy}, 16'h1);
    cmp("ch5_ready", {15'h0, req_ready}, 16'h0);
    $display("txn grant ch5: grant=%h id=%0d", grant, grant_id);
    done = 16'h0020; tick(); done = 16'h0;
    tick();

    // Channel 9: stray done[3] ignored, then done[9] with done[3].
    req_valid = 1'b1; req_id = 4'd9;
    tick(); req_valid = 1'b0;
    tick();
    done = 16'h0008; tick();
    cmp("ch9_ign3", grant, 16'h0200);
    done = 16'h0208; tick(); done = 16'h0;
    cmp("ch9_rel", grant, 16'h0000);
    cmp("ch9_rel_ready", {15'h0, req_ready}, 16'h0);
    tick();
    cmp("ch9_ready", {15'h0, req_ready}, 16'h1);
    cmp("ch9_id_hold", {12'h0, grant_id}, 16'h9);
    $display("txn grant ch9 done: ready=%b id=%0d", req_ready, grant_id);

    // Channel 15 times out after exactly TMO cycles.
    req_valid = 1'b1; req_id = 4'd15;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      cmp("ch15_hold", grant, 16'h8000);
      tick();
    end
    cmp("ch15_tmo_grant", grant, 16'h0000);
    cmp("ch15_tmo_err", {15'h0, timeout_err}, 16'h1);
    tick();
    cmp("ch15_err_clr", {15'h0, timeout_err}, 16'h0);
    $display("txn grant ch15 timeout");

    // Channel 15: done, abort and timeout coincide; done wins, no error.
    req_valid = 1'b1; req_id = 4'd15;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    done = 16'h8000; abort = 1'b1;
    tick(); done = 16'h0; abort = 1'b0;
    cmp("ch15_coinc_grant", grant, 16'h0000);
    cmp("ch15_coinc_err", {15'h0, timeout_err}, 16'h0);
    tick();
    $display("txn grant ch15 done at timeout");

    // abort held in IDLE does not block acceptance; it then releases.
    abort = 1'b1; req_valid = 1'b1; req_id = 4'd0;
    tick(); req_valid = 1'b0;
    cmp("ch0_grant", grant, 16'h0001);
    tick(); abort = 1'b0;
    cmp("ch0_abort", grant, 16'h0000);
    cmp("ch0_abort_err", {15'h0, timeout_err}, 16'h0);
    tick();
    $display("txn grant ch0 abort");

    // Reset mid-grant on channel 7, then a fresh request on channel 2.
    req_valid = 1'b1; req_id = 4'd7;
    tick(); req_valid = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cmp("rst7_grant", grant, 16'h0000);
    cmp("rst7_id", {12'h0, grant_id}, 16'h0);
    cmp("rst7_busy", {15'h0, busy}, 16'h0);
    cmp("rst7_ready", {15'h0, req_ready}, 16'h1);
    req_valid = 1'b1; req_id = 4'd2;
    tick(); req_valid = 1'b0;
    cmp("ch2_grant", grant, 16'h0004);
    done = 16'h0004; tick(); done = 16'h0;
    tick(); tick();
    $display("txn reset mid-grant then ch2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/merak_channel_grant_decoder.md
# merak_channel_grant_decoder

Registered 4-to-16 grant decoder for the Merak channel arbiter. It accepts an encoded channel index and valid flag from the 16-to-4 priority encoder stage, drives a one-hot grant to the selected channel and holds it until that channel signals done. A timeout counter revokes stale grants, and an abort input forces early release. A one-cycle release gap separates consecutive grants, so two grants are never asserted together.

## Interface
Parameters:
- TIMEOUT, 200: maximum grant duration in cycles; legal range 1 .. 2^CNT_W-1.
- CNT_W, 8: width of the grant-duration counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  1  encoder output valid; an encoded channel request is present.
- req_id  input  4  encoded channel index, meaningful only when req_valid=1.
- req_ready  output  1  block can accept a request; equals (state==IDLE).
- grant  output  16  registered one-hot grant; bit i grants channel i.
- grant_id  output  4  registered index of the current or last granted channel.
- busy  output  1  registered; 1 in GRANT and RELEASE.
- done  input  16  per-channel completion; only done[grant_id] is honoured in GRANT.
- abort  input  1  forces release of the active grant without an error.
- timeout_err  output  1  registered one-cycle pulse when a grant expires.

## Operation
- States: IDLE, GRANT, RELEASE (2-bit encoding; unused encodings go to IDLE).
- IDLE:
  - req_ready=1.
  - If req_valid=1 at an edge: latch grant_id<=req_id, grant<=16'h1<<req_id, cnt<=0, next state GRANT.
  - abort and done are ignored in IDLE.
- GRANT:
  - req_ready=0; req_valid and req_id are ignored.
  - Each edge, priority order:
    1. done[grant_id]=1 -> grant<=0, next state RELEASE.
    2. else abort=1 -> grant<=0, next state RELEASE, no error.
    3. else cnt==TIMEOUT-1 -> grant<=0, timeout_err<=1, next state RELEASE.
    4. else cnt<=cnt+1.
  - done bits of non-granted channels have no effect.
- RELEASE:
  - grant=0 for exactly one cycle; timeout_err clears at the next edge.
  - Next state IDLE unconditionally.
- grant_id holds its value after release until the next acceptance.
- Reset (rst_n=0 at an edge), in any state including mid-grant: state<=IDLE, grant<=0, grant_id<=0, busy<=0, timeout_err<=0, cnt<=0. No timeout_err pulse is produced by reset.
- Reset values: grant=16'h0000, grant_id=4'h0, busy=0, timeout_err=0, req_ready=1 once state=IDLE.
- cnt never wraps; it is bounded by TIMEOUT-1.

## Timing
- Acceptance edge E (req_valid=1, req_ready=1): grant and busy are high from cycle E+1.
- done[grant_id] sampled high at edge D: grant is low in cycle D+1 (RELEASE), state is IDLE in D+2, and the earliest new acceptance is at the end of D+2.
- Minimum grant length is 1 cycle (done already high at the first GRANT edge).
- Maximum grant length is TIMEOUT cycles. With no done, grant is high for cycles E+1..E+TIMEOUT, and timeout_err is high in cycle E+TIMEOUT+1.
- done, abort and timeout in the same cycle: done wins and timeout_err stays 0.
- Back-to-back throughput: one grant per (grant length + 2) cycles.

## Test plan
- Reset, then req_valid=1, req_id=4'd5 -> in the next cycle grant=16'h0020, grant_id=5, busy=1, req_ready=0.
- Grant on ch 9, done[9] pulsed 3 cycles after grant -> grant=0 in the next cycle. Concurrent done[3] is ignored. req_ready returns 1 two cycles after done.
- TIMEOUT=4, grant on ch 15 with no done -> grant=16'h8000 for exactly 4 cycles, then timeout_err=1 for one cycle with grant=0.
- TIMEOUT=4, done[15] and timeout coincide on the 4th cycle -> release with timeout_err=0.
- abort=1 during grant on ch 0 -> grant=0 in the next cycle, timeout_err=0. abort held in IDLE with req_valid=1 -> request still accepted.
- rst_n=0 for one edge mid-grant on ch 7 -> next cycle grant=0, grant_id=0, busy=0, timeout_err=0, req_ready=1. A new request with req_id=2 gives grant=16'h0004 one cycle after acceptance.
